// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control sequencer:
// state codes, opcodes, datapath select encodings and the raw control word.
package mc_pkg;

    localparam int MC_STATE_W = 4;

    typedef enum logic [MC_STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_BREG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Raw per-state control word, before mem_ready / zero / reset gating.
    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the sequencer (master) and the multicycle datapath (slave).
interface mc_ctrl_fsm_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  op, zero, mem_ready,
        output iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, aluop, pcsrc, pcen, instr_done, illegal_op
    );

    modport slave (
        output op, zero, mem_ready,
        input  iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, aluop, pcsrc, pcen, instr_done, illegal_op
    );
endinterface

// File: rtl/mc_outdec.sv
// Moore output decoder: state code to the raw (ungated) datapath control word.
module mc_outdec
    import mc_pkg::*;
(
    input  logic [MC_STATE_W-1:0] state,
    output ctrl_t                 ctrl
);

    // Per-state control word; unlisted fields and unused encodings stay zero.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                ctrl.pcwrite = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.memtoreg   = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord       = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_BREG;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regdst     = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_BREG;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.branch     = 1'b1;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JEX: begin
                ctrl.pcsrc      = PCSRC_JUMP;
                ctrl.pcwrite    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS sequencer: state register, next-state logic, and the
// mem_ready / zero / reset gating applied on top of the Moore control word.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int USE_MEM_READY = 1,
    parameter int STATE_W       = MC_STATE_W
) (
    input  logic          clk,
    input  logic          reset,
    mc_ctrl_fsm_if.master bus
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               mem_rdy;
    logic               rdy_gate;
    logic               illegal_d;
    ctrl_t              ctrl;

    assign mem_rdy = (USE_MEM_READY != 0) ? bus.mem_ready : 1'b1;

    mc_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; op is only consulted in DECODE and MEMADR.
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:   state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_rdy ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // FETCH commits IR/PC and MEMWR completes only on the cycle memory is ready.
    always_comb begin
        if ((state_q == S_FETCH) || (state_q == S_MEMWR)) begin
            rdy_gate = mem_rdy;
        end else begin
            rdy_gate = 1'b1;
        end
    end

    // Output gating; reset forces every enable and select low.
    always_comb begin
        if (reset) begin
            bus.iord       = 1'b0;
            bus.irwrite    = 1'b0;
            bus.memwrite   = 1'b0;
            bus.regwrite   = 1'b0;
            bus.regdst     = 1'b0;
            bus.memtoreg   = 1'b0;
            bus.alusrca    = 1'b0;
            bus.alusrcb    = 2'b00;
            bus.aluop      = 2'b00;
            bus.pcsrc      = 2'b00;
            bus.pcen       = 1'b0;
            bus.instr_done = 1'b0;
            bus.illegal_op = 1'b0;
        end else begin
            bus.iord       = ctrl.iord;
            bus.irwrite    = ctrl.irwrite & rdy_gate;
            bus.memwrite   = ctrl.memwrite;
            bus.regwrite   = ctrl.regwrite;
            bus.regdst     = ctrl.regdst;
            bus.memtoreg   = ctrl.memtoreg;
            bus.alusrca    = ctrl.alusrca;
            bus.alusrcb    = ctrl.alusrcb;
            bus.aluop      = ctrl.aluop;
            bus.pcsrc      = ctrl.pcsrc;
            bus.pcen       = (ctrl.pcwrite & rdy_gate) | (ctrl.branch & bus.zero);
            bus.instr_done = ctrl.instr_done & rdy_gate;
            bus.illegal_op = illegal_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed-vector bench for mc_ctrl_fsm: each cycle checks the state and the
// full packed output word against hand-computed constants.
module tb_mc_ctrl_fsm;
    import mc_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(.USE_MEM_READY(1), .STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
    //  alusrcb[1:0], aluop[1:0], pcsrc[1:0], pcen, instr_done, illegal_op}
    logic [15:0] out_w;
    assign out_w = {bus.iord, bus.irwrite, bus.memwrite, bus.regwrite, bus.regdst,
                    bus.memtoreg, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc,
                    bus.pcen, bus.instr_done, bus.illegal_op};

    localparam logic [15:0] W_ZERO      = 16'h0000;
    localparam logic [15:0] W_FETCH     = 16'h4084;
    localparam logic [15:0] W_FETCH_WT  = 16'h0080;
    localparam logic [15:0] W_DECODE    = 16'h0180;
    localparam logic [15:0] W_DECODE_IL = 16'h0181;
    localparam logic [15:0] W_MEMADR    = 16'h0300;
    localparam logic [15:0] W_MEMRD     = 16'h8000;
    localparam logic [15:0] W_MEMWB     = 16'h1402;
    localparam logic [15:0] W_MEMWR_WT  = 16'hA000;
    localparam logic [15:0] W_MEMWR     = 16'hA002;
    localparam logic [15:0] W_RTYPEEX   = 16'h0240;
    localparam logic [15:0] W_RTYPEWB   = 16'h1802;
    localparam logic [15:0] W_BEQ_TAKEN = 16'h022E;
    localparam logic [15:0] W_BEQ_NOT   = 16'h022A;
    localparam logic [15:0] W_ADDIEX    = 16'h0300;
    localparam logic [15:0] W_ADDIWB    = 16'h1002;
    localparam logic [15:0] W_JEX       = 16'h0016;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the current cycle (inputs already applied), then advance one clock.
    task automatic cyc(input string tag, input state_e exp_st, input logic [15:0] exp_w);
        #1;
        chk({tag, ".state"}, 32'(dut.state_q), 32'(exp_st));
        chk({tag, ".out"}, 32'(out_w), 32'(exp_w));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.op        = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", S_FETCH, W_ZERO);
        reset = 1'b0;

        // LW, no stalls: 5 cycles
        bus.op = OP_LW;
        cyc("lw.fetch",  S_FETCH,  W_FETCH);
        cyc("lw.decode", S_DECODE, W_DECODE);
        cyc("lw.memadr", S_MEMADR, W_MEMADR);
        cyc("lw.memrd",  S_MEMRD,  W_MEMRD);
        cyc("lw.memwb",  S_MEMWB,  W_MEMWB);

        // SW with two wait cycles in MEMWR: 6 cycles
        bus.op = OP_SW;
        cyc("sw.fetch",  S_FETCH,  W_FETCH);
        cyc("sw.decode", S_DECODE, W_DECODE);
        cyc("sw.memadr", S_MEMADR, W_MEMADR);
        bus.mem_ready = 1'b0;
        cyc("sw.memwr0", S_MEMWR, W_MEMWR_WT);
        cyc("sw.memwr1", S_MEMWR, W_MEMWR_WT);
        bus.mem_ready = 1'b1;
        cyc("sw.memwr2", S_MEMWR, W_MEMWR);

        // LW with one wait cycle in MEMRD
        bus.op = OP_LW;
        cyc("lws.fetch",  S_FETCH,  W_FETCH);
        cyc("lws.decode", S_DECODE, W_DECODE);
        cyc("lws.memadr", S_MEMADR, W_MEMADR);
        bus.mem_ready = 1'b0;
        cyc("lws.memrd0", S_MEMRD, W_MEMRD);
        bus.mem_ready = 1'b1;
        cyc("lws.memrd1", S_MEMRD, W_MEMRD);
        cyc("lws.memwb",  S_MEMWB, W_MEMWB);

        // BEQ taken, then not taken
        bus.op = OP_BEQ;
        cyc("beq1.fetch",  S_FETCH,  W_FETCH);
        cyc("beq1.decode", S_DECODE, W_DECODE);
        bus.zero = 1'b1;
        cyc("beq1.ex", S_BEQEX, W_BEQ_TAKEN);
        bus.zero = 1'b0;
        cyc("beq0.fetch",  S_FETCH,  W_FETCH);
        cyc("beq0.decode", S_DECODE, W_DECODE);
        cyc("beq0.ex",     S_BEQEX,  W_BEQ_NOT);

        // RTYPE then ADDI
        bus.op = OP_RTYPE;
        cyc("rt.fetch",  S_FETCH,   W_FETCH);
        cyc("rt.decode", S_DECODE,  W_DECODE);
        cyc("rt.ex",     S_RTYPEEX, W_RTYPEEX);
        cyc("rt.wb",     S_RTYPEWB, W_RTYPEWB);
        bus.op = OP_ADDI;
        cyc("addi.fetch",  S_FETCH,  W_FETCH);
        cyc("addi.decode", S_DECODE, W_DECODE);
        cyc("addi.ex",     S_ADDIEX, W_ADDIEX);
        cyc("addi.wb",     S_ADDIWB, W_ADDIWB);

        // Illegal opcode, then J with one FETCH wait cycle
        bus.op = 6'b111111;
        cyc("ill.fetch",  S_FETCH,  W_FETCH);
        cyc("ill.decode", S_DECODE, W_DECODE_IL);
        bus.op        = OP_J;
        bus.mem_ready = 1'b0;
        cyc("j.fetch_wt", S_FETCH, W_FETCH_WT);
        bus.mem_ready = 1'b1;
        cyc("j.fetch",  S_FETCH,  W_FETCH);
        cyc("j.decode", S_DECODE, W_DECODE);
        cyc("j.ex",     S_JEX,    W_JEX);

        // Reset while stalled in MEMWR
        bus.op = OP_SW;
        cyc("swr.fetch",  S_FETCH,  W_FETCH);
        cyc("swr.decode", S_DECODE, W_DECODE);
        cyc("swr.memadr", S_MEMADR, W_MEMADR);
        bus.mem_ready = 1'b0;
        cyc("swr.memwr", S_MEMWR, W_MEMWR_WT);
        reset = 1'b1;
        cyc("swr.rst", S_MEMWR, W_ZERO);
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        cyc("swr.fetch2",  S_FETCH,  W_FETCH);
        cyc("swr.decode2", S_DECODE, W_DECODE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
